// File: rtl/conv_result_writer_pkg.sv
// ============================================================================
// Module      : conv_result_writer_pkg
// Description : Shared types and constants for the convolution write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_result_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 480;
    localparam int DEF_HEIGHT   = 272;
    localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;

    // RGB888 packing: R in the top byte
    localparam int CH_W     = 8;
    localparam int RGB_R_LO = 16;
    localparam int RGB_G_LO = 8;
    localparam int RGB_B_LO = 0;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_result_writer_chan_reduce.sv
// ============================================================================
// Module      : chan_reduce
// Description : Reduces one signed MAC sum to an 8-bit channel value.
//               Saturating when CONV_SAT_EN is defined, truncating otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_reduce #(
    parameter int SUM_W = 16
) (
    input  logic [SUM_W-1:0] iSum,
    output logic [7:0]       oPix
);

`ifdef CONV_SAT_EN
    logic w_neg;
    logic w_over;

    assign w_neg  = iSum[SUM_W-1];
    assign w_over = |iSum[SUM_W-2:8];

    always_comb begin
        oPix = iSum[7:0];
        if (w_neg) begin
            oPix = 8'h00;
        end else if (w_over) begin
            oPix = 8'hFF;
        end
    end
`else
    logic w_unusedHi;

    assign w_unusedHi = ^iSum[SUM_W-1:8];
    assign oPix       = iSum[7:0];
`endif

endmodule

`default_nettype wire

// File: rtl/conv_result_writer.sv
// ============================================================================
// Module      : conv_result_writer
// Description : Writes convolved RGB888 pixels in raster order into the frame
//               BRAM through a small skid FIFO. Build option: CONV_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_writer
    import conv_result_writer_pkg::*;
#(
    parameter int SUM_W      = 16,
    parameter int ADDR_W     = 17,
    parameter int WIDTH      = 480,
    parameter int HEIGHT     = 272,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEn,
    input  logic               iValid,
    input  logic [3*SUM_W-1:0] iData,
    output logic               oBusy,
    output logic               oCs,
    output logic               oWe,
    output logic [ADDR_W-1:0]  oAddr,
    output logic [23:0]        oData,
    input  logic               iMemBusy,
    output logic               oFrameDone
);

    localparam int FRAME_N = frame_pixels(WIDTH, HEIGHT);
    localparam int CNT_W   = $clog2(FRAME_N + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    state_t             r_state;
    state_t             w_stateNext;
    logic [23:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [LVL_W-1:0]   r_level;
    logic [CNT_W-1:0]   r_acceptCnt;
    logic [ADDR_W-1:0]  r_writeCnt;
    logic               r_cs;
    logic [ADDR_W-1:0]  r_addr;
    logic [23:0]        r_data;

    logic [23:0]        w_pix;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_lastAccept;

    chan_reduce #(.SUM_W(SUM_W)) u_redR (
        .iSum (iData[3*SUM_W-1:2*SUM_W]),
        .oPix (w_pix[RGB_R_LO +: CH_W])
    );

    chan_reduce #(.SUM_W(SUM_W)) u_redG (
        .iSum (iData[2*SUM_W-1:SUM_W]),
        .oPix (w_pix[RGB_G_LO +: CH_W])
    );

    chan_reduce #(.SUM_W(SUM_W)) u_redB (
        .iSum (iData[SUM_W-1:0]),
        .oPix (w_pix[RGB_B_LO +: CH_W])
    );

    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);

    // Backpressure only looks at registers so upstream never sees a loop
    assign oBusy = w_full || (r_state == ST_FLUSH) || (r_state == ST_DONE);

    // Pop reads registered FIFO contents only; an empty FIFO never bypasses
    assign w_push       = iEn && iValid && !oBusy;
    assign w_pop        = iEn && !iMemBusy && !w_empty;
    assign w_lastAccept = w_push && (r_acceptCnt == CNT_W'(FRAME_N - 1));

    always_comb begin
        w_stateNext = r_state;
        if (iEn) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_lastAccept) begin
                        w_stateNext = ST_FLUSH;
                    end else if (w_push) begin
                        w_stateNext = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_lastAccept) begin
                        w_stateNext = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_empty) begin
                        w_stateNext = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_stateNext = ST_IDLE;
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= w_pix;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_level     <= '0;
            r_acceptCnt <= '0;
            r_writeCnt  <= '0;
            r_cs        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cs    <= w_pop;

            if (w_push) begin
                r_wrPtr     <= r_wrPtr + PTR_W'(1);
                r_acceptCnt <= r_acceptCnt + CNT_W'(1);
            end

            if (w_pop) begin
                r_data  <= r_fifo[r_rdPtr];
                r_addr  <= r_writeCnt;
                r_rdPtr <= r_rdPtr + PTR_W'(1);
                if (r_writeCnt == ADDR_W'(FRAME_N - 1)) begin
                    r_writeCnt <= '0;
                end else begin
                    r_writeCnt <= r_writeCnt + ADDR_W'(1);
                end
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end

            if (iEn && (r_state == ST_DONE)) begin
                r_acceptCnt <= '0;
                r_writeCnt  <= '0;
            end
        end
    end

    assign oCs        = r_cs;
    assign oWe        = r_cs;
    assign oAddr      = r_addr;
    assign oData      = r_data;
    assign oFrameDone = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writer.sv
// ============================================================================
// Module      : tb_conv_result_writer
// Description : Directed self-checking bench for conv_result_writer (4x3 frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_result_writer;

    localparam int SUM_W  = 16;
    localparam int ADDR_W = 17;
    localparam int FRAME  = 12;

    logic                iClk = 1'b0;
    logic                iRst;
    logic                iEn;
    logic                iValid;
    logic [3*SUM_W-1:0]  iData;
    logic                iMemBusy;
    logic                oBusy;
    logic                oCs;
    logic                oWe;
    logic [ADDR_W-1:0]   oAddr;
    logic [23:0]         oData;
    logic                oFrameDone;

    int          nCmp    = 0;
    int          nErr    = 0;
    int          nDone   = 0;
    int          expAddr = 0;
    logic [23:0] expQ [$];
    logic [23:0] curExp;
    bit          lastAcc;

    conv_result_writer #(
        .SUM_W      (SUM_W),
        .ADDR_W     (ADDR_W),
        .WIDTH      (4),
        .HEIGHT     (3),
        .FIFO_DEPTH (2)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iValid     (iValid),
        .iData      (iData),
        .oBusy      (oBusy),
        .oCs        (oCs),
        .oWe        (oWe),
        .oAddr      (oAddr),
        .oData      (oData),
        .iMemBusy   (iMemBusy),
        .oFrameDone (oFrameDone)
    );

    always #5 iClk = ~iClk;

    function automatic logic [47:0] pk(input logic [15:0] r, input logic [15:0] g,
                                       input logic [15:0] b);
        return {r, g, b};
    endfunction

    function automatic logic [23:0] w3(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, b, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; scoreboards every write that the edge produces
    task automatic tick();
        bit acc;
        bit stall;
        acc   = iEn && iValid && !oBusy && !iRst;
        stall = iMemBusy || !iEn;
        @(posedge iClk);
        #1;
        if (acc) expQ.push_back(curExp);
        lastAcc = acc;
        nDone += int'(oFrameDone);
        if (stall) chk("no_write_stall", {31'd0, oCs}, 32'd0);
        if (oCs) begin
            chk("waddr", {15'd0, oAddr}, expAddr);
            chk("we", {31'd0, oWe}, 32'd1);
            if (expQ.size() == 0) begin
                nCmp++;
                nErr++;
                $error("FAIL wdata: observed 0x%0h expected no write", oData);
            end else begin
                chk("wdata", {8'd0, oData}, {8'd0, expQ.pop_front()});
            end
            expAddr = (expAddr + 1) % FRAME;
        end
    endtask

    task automatic push(input logic [47:0] d, input logic [23:0] e, output int n);
        iValid = 1'b1;
        iData  = d;
        curExp = e;
        n      = 0;
        do begin
            tick();
            n++;
        end while (!lastAcc && n < 20);
        if (!lastAcc) begin
            nCmp++;
            nErr++;
            $error("FAIL push_timeout: observed no accept expected accept");
        end
    endtask

    task automatic pushIdx(input int i, output int n);
        push(pk(i[15:0], i[15:0], i[15:0]), w3(i), n);
    endtask

    task automatic chkOutputsZero(input string tag);
        chk({tag, "_cs"},   {31'd0, oCs},        32'd0);
        chk({tag, "_we"},   {31'd0, oWe},        32'd0);
        chk({tag, "_addr"}, {15'd0, oAddr},      32'd0);
        chk({tag, "_data"}, {8'd0, oData},       32'd0);
        chk({tag, "_busy"}, {31'd0, oBusy},      32'd0);
        chk({tag, "_done"}, {31'd0, oFrameDone}, 32'd0);
    endtask

    initial begin
        int          n;
        logic [23:0] e0;
        logic [23:0] e1;
        logic [16:0] hold;

        iRst     = 1'b1;
        iEn      = 1'b1;
        iValid   = 1'b0;
        iMemBusy = 1'b0;
        iData    = '0;
        curExp   = '0;
        repeat (2) @(posedge iClk);
        #1;
        chkOutputsZero("reset");
        iRst = 1'b0;

        // Frame A: 12 back-to-back pixels, R=G=B=index
        pushIdx(0, n);
        chk("thru_0", n, 1);
        chk("lat_e0", {31'd0, oCs}, 32'd0);
        pushIdx(1, n);
        chk("lat_e1", {31'd0, oCs}, 32'd1);
        for (int i = 2; i < FRAME; i++) begin
            pushIdx(i, n);
            chk("thru", n, 1);
        end
        iValid = 1'b0;
        tick();
        chk("busy_flush", {31'd0, oBusy}, 32'd1);
        chk("last_addr", {15'd0, oAddr}, 32'd11);
        tick();
        chk("frame_done", {31'd0, oFrameDone}, 32'd1);
        tick();
        chk("done_clear", {31'd0, oFrameDone}, 32'd0);
        chk("idle_busy", {31'd0, oBusy}, 32'd0);
        chk("done_once_a", nDone, 1);
        chk("q_empty_a", expQ.size(), 0);

        // Frame B: channel reduction, memory stall, enable gap
        nDone = 0;
`ifdef CONV_SAT_EN
        e0 = 24'h00FF80;
        e1 = 24'hFF0080;
`else
        e0 = 24'hFB2C80;
        e1 = 24'h2CFB80;
`endif
        push(pk(16'hFFFB, 16'h012C, 16'h0080), e0, n);
        push(pk(16'h012C, 16'hFFFB, 16'h0080), e1, n);
        chk("reduce_0", {8'd0, oData}, {8'd0, e0});
        iValid = 1'b0;
        tick();
        chk("reduce_1", {8'd0, oData}, {8'd0, e1});
        tick();

        iMemBusy = 1'b1;
        pushIdx(2, n);
        chk("busy_pre", {31'd0, oBusy}, 32'd0);
        pushIdx(3, n);
        chk("busy_full", {31'd0, oBusy}, 32'd1);
        iValid = 1'b1;
        iData  = pk(16'd4, 16'd4, 16'd4);
        curExp = w3(4);
        repeat (3) begin
            tick();
            chk("stall_busy", {31'd0, oBusy}, 32'd1);
        end
        iMemBusy = 1'b0;
        pushIdx(4, n);
        pushIdx(5, n);

        hold   = oAddr;
        iEn    = 1'b0;
        iValid = 1'b1;
        iData  = pk(16'd6, 16'd6, 16'd6);
        curExp = w3(6);
        repeat (3) begin
            tick();
            chk("en_hold_addr", {15'd0, oAddr}, {15'd0, hold});
        end
        iEn = 1'b1;
        for (int i = 6; i < FRAME; i++) begin
            pushIdx(i, n);
        end
        iValid = 1'b0;
        repeat (5) tick();
        chk("done_once_b", nDone, 1);
        chk("q_empty_b", expQ.size(), 0);
        chk("addr_wrap_b", expAddr, 0);

        // Frame C: reset after 6 pixels discards the partial frame
        for (int i = 0; i < 6; i++) begin
            pushIdx(i, n);
        end
        iValid = 1'b0;
        iRst   = 1'b1;
        @(posedge iClk);
        #1;
        chkOutputsZero("midrst");
        iRst = 1'b0;
        expQ.delete();
        expAddr = 0;

        // Frame D: restarts at address 0
        nDone = 0;
        pushIdx(0, n);
        pushIdx(1, n);
        chk("rst_cs0", {31'd0, oCs}, 32'd1);
        chk("rst_addr0", {15'd0, oAddr}, 32'd0);
        for (int i = 2; i < FRAME; i++) begin
            pushIdx(i, n);
        end
        iValid = 1'b0;
        repeat (5) tick();
        chk("done_once_d", nDone, 1);
        chk("q_empty_d", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

`default_nettype wire
